regfile_wb_scheduler: RTL and testbench

//  Writeback scheduler and scoreboard for the 32-entry RegisterFile.

---
 rtl/regfile_wb_scheduler.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Writeback scheduler and RAW scoreboard for the 32-entry RegisterFile.
// Several writeback sources share the single RegisterFile write port through
// a round-robin valid/ready arbiter. The winning request is registered into an
// output stage that drives RegWrite/Rd/WriteData. A pending-register scoreboard
// is set at issue time and cleared when the write lands, so decode can stall.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester writeback valid
//   req_rd     per-requester destination, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant, a transfer happens on valid & ready
//   rsv_valid  issue stage wants to reserve rsv_rd
//   rsv_rd     register to reserve
//   rsv_ready  reservation can be accepted this cycle
//   chk_rs1    source register 1 to check for a pending write
//   chk_rs2    source register 2 to check for a pending write
//   rs1_busy   chk_rs1 has a pending write
//   rs2_busy   chk_rs2 has a pending write
//   RegWrite   RegisterFile write enable
//   Rd         RegisterFile write address
//   WriteData  RegisterFile write data
module regfile_wb_scheduler #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREQ       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_rd,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       rsv_valid,
    input  logic [ADDR_WIDTH-1:0]      rsv_rd,
    output logic                       rsv_ready,
    input  logic [ADDR_WIDTH-1:0]      chk_rs1,
    input  logic [ADDR_WIDTH-1:0]      chk_rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic                       RegWrite,
    output logic [ADDR_WIDTH-1:0]      Rd,
    output logic [WIDTH-1:0]           WriteData
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic                  grant_found;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [WIDTH-1:0]      sel_data;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_next;
    logic                  rsv_fire;

    // Round-robin search: the first valid requester found when walking
    // cyclically from rr_ptr wins. rr_ptr always stays below NREQ, so the
    // modulo keeps every probe inside the requester range.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Grants are suppressed while reset is held so no transfer can be
    // observed by a requester during reset.
    assign transfer = rst & grant_found;

    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = transfer && (grant_idx == PTR_W'(j));
        end
    end

    assign sel_rd   = req_rd[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign next_ptr = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // Output stage and arbiter pointer. A granted x0 request is consumed but
    // never raises RegWrite. Without a transfer the address/data hold their
    // last value and only the write enable drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            RegWrite  <= 1'b0;
            Rd        <= '0;
            WriteData <= '0;
        end else if (transfer) begin
            rr_ptr    <= next_ptr;
            RegWrite  <= (sel_rd != '0);
            Rd        <= sel_rd;
            WriteData <= sel_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // A register that is already pending cannot be reserved again; x0 can
    // always be "reserved" because it never becomes pending.
    assign rsv_ready = rst & ((rsv_rd == '0) | ~pending[rsv_rd]);
    assign rsv_fire  = rsv_valid & rsv_ready & (rsv_rd != '0);

    // Clear on the edge the RegisterFile takes the write, then apply a new
    // reservation so that a set and a clear of the same register leave it
    // pending. Bit 0 is forced low so x0 never reports busy.
    always_comb begin
        pending_next = pending;
        if (RegWrite) begin
            pending_next[Rd] = 1'b0;
        end
        if (rsv_fire) begin
            pending_next[rsv_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // No bypass from the output stage: a source stays busy until the write
    // edge has actually passed.
    assign rs1_busy = pending[chk_rs1];
    assign rs2_busy = pending[chk_rs2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler
// Directed table of per-cycle vectors, a randomized phase checked against a
// behavioural model, and a hand-written reset-during-write sequence. A small
// RegisterFile stand-in captures the writes the scheduler issues.
module tb_regfile_wb_scheduler;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*AW-1:0] req_rd = '0;
    logic [NR*W-1:0]  req_data = '0;
    logic [NR-1:0]  req_ready;
    logic           rsv_valid = 1'b0;
    logic [AW-1:0]  rsv_rd = '0;
    logic           rsv_ready;
    logic [AW-1:0]  chk_rs1 = '0;
    logic [AW-1:0]  chk_rs2 = '0;
    logic           rs1_busy;
    logic           rs2_busy;
    logic           RegWrite;
    logic [AW-1:0]  Rd;
    logic [W-1:0]   WriteData;

    int n_checks = 0;
    int n_fails  = 0;

    logic [W-1:0] rf [32];

    regfile_wb_scheduler #(.WIDTH(W), .ADDR_WIDTH(AW), .NREQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .Rd(Rd), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    // RegisterFile stand-in: writes whatever the scheduler presents.
    always @(posedge clk) begin
        if (RegWrite) rf[Rd] <= WriteData;
    end

    typedef struct {
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] data;
        logic        rv;
        logic [4:0]  rr;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic [2:0]  e_ready;
        logic        e_rsv;
        logic        e_b1;
        logic        e_b2;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic [31:0] e_rf;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t vec(
        input logic [2:0] v, input logic [4:0] rd0, rd1, rd2,
        input logic [31:0] d0, d1, d2, input logic rv, input logic [4:0] rr,
        input logic [4:0] c1, c2, input logic [2:0] e_ready, input logic e_rsv,
        input logic e_b1, e_b2, e_we, input logic [4:0] e_rd,
        input logic [31:0] e_wd, e_rf);
        vec_t r;
        r.v = v; r.rd = {rd2, rd1, rd0}; r.data = {d2, d1, d0};
        r.rv = rv; r.rr = rr; r.c1 = c1; r.c2 = c2;
        r.e_ready = e_ready; r.e_rsv = e_rsv; r.e_b1 = e_b1; r.e_b2 = e_b2;
        r.e_we = e_we; r.e_rd = e_rd; r.e_wd = e_wd; r.e_rf = e_rf;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t s);
        req_valid = s.v;
        req_rd    = s.rd;
        req_data  = s.data;
        rsv_valid = s.rv;
        rsv_rd    = s.rr;
        chk_rs1   = s.c1;
        chk_rs2   = s.c2;
    endtask

    // Behavioural reference state for the random phase.
    int          m_ptr;
    bit          m_pend [32];
    logic [31:0] m_rf [32];
    bit          m_we;
    int          m_rd;
    logic [31:0] m_wd;
    bit          q_v [NR];
    int          q_rd [NR];
    logic [31:0] q_d [NR];
    int          q_wait [NR];

    function automatic int firstFrom(input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (q_v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        vec_t idle;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Expected values derived cycle by cycle from reset (ptr 0, nothing pending).
        //          v       rd0 rd1 rd2 d0        d1        d2            rv rr c1 c2   rdy     rsv b1 b2 we rd wd            rf
        tbl[0]  = vec(3'b001, 5, 0, 0, 32'h64,   32'h0,   32'h0,          0, 0, 5, 0, 3'b001, 1, 0, 0, 0, 0, 32'h0,        32'h0);
        tbl[1]  = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 0, 5, 0, 3'b000, 1, 0, 0, 1, 5, 32'h64,       32'h0);
        tbl[2]  = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 0, 5, 0, 3'b000, 1, 0, 0, 0, 5, 32'h64,       32'h64);
        tbl[3]  = vec(3'b100, 0, 0, 0, 32'h0,    32'h0,   32'hDEADBEEF,   0, 0, 0, 0, 3'b100, 1, 0, 0, 0, 5, 32'h64,       32'h0);
        tbl[4]  = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        tbl[5]  = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        tbl[6]  = vec(3'b111, 1, 2, 3, 32'h11,   32'h22,  32'h33,         0, 0, 1, 0, 3'b001, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
        tbl[7]  = vec(3'b110, 1, 2, 3, 32'h11,   32'h22,  32'h33,         0, 0, 1, 0, 3'b010, 1, 0, 0, 1, 1, 32'h11,       32'h0);
        tbl[8]  = vec(3'b100, 1, 2, 3, 32'h11,   32'h22,  32'h33,         0, 0, 2, 0, 3'b100, 1, 0, 0, 1, 2, 32'h22,       32'h0);
        tbl[9]  = vec(3'b010, 0, 4, 0, 32'h0,    32'h44,  32'h0,          0, 0, 3, 0, 3'b010, 1, 0, 0, 1, 3, 32'h33,       32'h0);
        tbl[10] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 0, 3, 0, 3'b000, 1, 0, 0, 1, 4, 32'h44,       32'h33);
        tbl[11] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 0, 4, 0, 3'b000, 1, 0, 0, 0, 4, 32'h44,       32'h44);
        tbl[12] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          1, 7, 7, 0, 3'b000, 1, 0, 0, 0, 4, 32'h44,       32'h0);
        tbl[13] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          1, 7, 7, 7, 3'b000, 0, 1, 1, 0, 4, 32'h44,       32'h0);
        tbl[14] = vec(3'b001, 7, 0, 0, 32'h77,   32'h0,   32'h0,          0, 7, 7, 0, 3'b001, 0, 1, 0, 0, 4, 32'h44,       32'h0);
        tbl[15] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 7, 7, 0, 3'b000, 0, 1, 0, 1, 7, 32'h77,       32'h0);
        tbl[16] = vec(3'b010, 0, 7, 0, 32'h0,    32'h78,  32'h0,          0, 7, 7, 0, 3'b010, 1, 0, 0, 0, 7, 32'h77,       32'h77);
        tbl[17] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          1, 7, 7, 0, 3'b000, 1, 0, 0, 1, 7, 32'h78,       32'h77);
        tbl[18] = vec(3'b000, 0, 0, 0, 32'h0,    32'h0,   32'h0,          0, 7, 7, 0, 3'b000, 0, 1, 0, 0, 7, 32'h78,       32'h78);
        idle = vec(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset: grants and reservations are blocked even with requests present.
        #1 rst = 1'b0;
        req_valid = 3'b111;
        #2;
        checkOutput("rst.req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst.rsv_ready", 64'(rsv_ready), 64'd0);
        checkOutput("rst.RegWrite", 64'(RegWrite), 64'd0);
        checkOutput("rst.Rd", 64'(Rd), 64'd0);
        checkOutput("rst.WriteData", 64'(WriteData), 64'd0);
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Idle after reset: nothing busy, nothing written.
        applyStimulus(idle);
        for (int a = 0; a < 32; a++) begin
            chk_rs1 = 5'(a);
            chk_rs2 = 5'(31 - a);
            #1;
            checkOutput($sformatf("idle.rs1_busy[%0d]", a), 64'(rs1_busy), 64'd0);
            checkOutput($sformatf("idle.rs2_busy[%0d]", a), 64'(rs2_busy), 64'd0);
            checkOutput($sformatf("idle.rf[%0d]", a), 64'(rf[a]), 64'd0);
        end
        checkOutput("idle.RegWrite", 64'(RegWrite), 64'd0);
        checkOutput("idle.Rd", 64'(Rd), 64'd0);
        checkOutput("idle.WriteData", 64'(WriteData), 64'd0);
        checkOutput("idle.rsv_ready", 64'(rsv_ready), 64'd1);

        // Directed table: one record per clock cycle.
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
            checkOutput($sformatf("vec%0d.rsv_ready", i), 64'(rsv_ready), 64'(tbl[i].e_rsv));
            checkOutput($sformatf("vec%0d.rs1_busy", i), 64'(rs1_busy), 64'(tbl[i].e_b1));
            checkOutput($sformatf("vec%0d.rs2_busy", i), 64'(rs2_busy), 64'(tbl[i].e_b2));
            checkOutput($sformatf("vec%0d.RegWrite", i), 64'(RegWrite), 64'(tbl[i].e_we));
            checkOutput($sformatf("vec%0d.Rd", i), 64'(Rd), 64'(tbl[i].e_rd));
            checkOutput($sformatf("vec%0d.WriteData", i), 64'(WriteData), 64'(tbl[i].e_wd));
            checkOutput($sformatf("vec%0d.rf", i), 64'(rf[tbl[i].c1]), 64'(tbl[i].e_rf));
        end

        // Fresh reset before the random phase; the RegisterFile keeps its contents.
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(idle);
        @(posedge clk);
        #1 rst = 1'b1;

        m_ptr = 0; m_we = 0; m_rd = 0; m_wd = '0;
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0;
            m_rf[i]   = '0;
        end
        m_rf[1] = 32'h11; m_rf[2] = 32'h22; m_rf[3] = 32'h33;
        m_rf[4] = 32'h44; m_rf[5] = 32'h64; m_rf[7] = 32'h78;
        for (int i = 0; i < NR; i++) begin
            q_v[i] = 0; q_rd[i] = 0; q_d[i] = '0; q_wait[i] = 0;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            int g;
            bit e_rsv;
            int c1, c2;
            for (int i = 0; i < NR; i++) begin
                if (!q_v[i] && ($urandom_range(0, 1) == 1)) begin
                    q_v[i]    = 1;
                    q_rd[i]   = int'($urandom_range(0, 7));
                    q_d[i]    = $urandom;
                    q_wait[i] = 0;
                end
                req_valid[i]          = q_v[i];
                req_rd[i*AW +: AW]    = 5'(q_rd[i]);
                req_data[i*W +: W]    = q_d[i];
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_rd    = 5'($urandom_range(0, 7));
            c1 = int'($urandom_range(0, 7));
            c2 = int'($urandom_range(0, 7));
            chk_rs1 = 5'(c1);
            chk_rs2 = 5'(c2);

            @(negedge clk);
            g     = firstFrom(m_ptr);
            e_rsv = (rsv_rd == 0) || !m_pend[rsv_rd];
            checkOutput("rand.req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            checkOutput("rand.rsv_ready", 64'(rsv_ready), 64'(e_rsv));
            checkOutput("rand.rs1_busy", 64'(rs1_busy), 64'(m_pend[c1]));
            checkOutput("rand.rs2_busy", 64'(rs2_busy), 64'(m_pend[c2]));
            checkOutput("rand.RegWrite", 64'(RegWrite), 64'(m_we));
            checkOutput("rand.Rd", 64'(Rd), 64'(m_rd));
            checkOutput("rand.WriteData", 64'(WriteData), 64'(m_wd));
            checkOutput("rand.rf", 64'(rf[c1]), 64'(m_rf[c1]));

            @(posedge clk);
            if (m_we) begin
                m_rf[m_rd]   = m_wd;
                m_pend[m_rd] = 0;
            end
            if (rsv_valid && e_rsv && rsv_rd != 0) m_pend[rsv_rd] = 1;
            if (g >= 0) begin
                checkOutput("rand.wait_bound", 64'(q_wait[g] <= NR - 1), 64'd1);
                m_we  = (q_rd[g] != 0);
                m_rd  = q_rd[g];
                m_wd  = q_d[g];
                m_ptr = (g + 1) % NR;
                q_v[g] = 0;
            end else begin
                m_we = 0;
            end
            for (int i = 0; i < NR; i++) begin
                if (q_v[i]) q_wait[i]++;
            end
            #1;
        end

        // Reset while a write sits in the output stage: the write is lost.
        applyStimulus(idle);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 3'b001;
        req_rd    = 15'd9;
        req_data  = 96'hAA;
        rsv_valid = 1'b1;
        rsv_rd    = 5'd9;
        chk_rs1   = 5'd9;
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        rsv_valid = 1'b0;
        #1;
        checkOutput("mid.RegWrite", 64'(RegWrite), 64'd1);
        checkOutput("mid.Rd", 64'(Rd), 64'd9);
        checkOutput("mid.WriteData", 64'(WriteData), 64'hAA);
        checkOutput("mid.busy", 64'(rs1_busy), 64'd1);
        #2 rst = 1'b0;
        req_valid = 3'b111;
        rsv_valid = 1'b1;
        rsv_rd    = 5'd0;
        #1;
        checkOutput("mid.rst.RegWrite", 64'(RegWrite), 64'd0);
        checkOutput("mid.rst.Rd", 64'(Rd), 64'd0);
        checkOutput("mid.rst.WriteData", 64'(WriteData), 64'd0);
        checkOutput("mid.rst.busy", 64'(rs1_busy), 64'd0);
        checkOutput("mid.rst.req_ready", 64'(req_ready), 64'd0);
        checkOutput("mid.rst.rsv_ready", 64'(rsv_ready), 64'd0);
        @(negedge clk);
        checkOutput("mid.rst.rf9", 64'(rf[9]), 64'd0);
        req_valid = 3'b000;
        rsv_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid.after.busy", 64'(rs1_busy), 64'd0);
        checkOutput("mid.after.rf9", 64'(rf[9]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
